// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side definitions: data widths, reset/NOP constants,
// fetch FSM encoding and the IF/ID payload type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ifid_t;

    // Instruction addresses are word aligned; low bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Request/grant/response instruction-memory port between the fetch unit
// (master) and instruction memory (slave).
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_skid_reg.sv
// One-entry {instr,pc} buffer that parks a fetched word while IF/ID is stalled.
module fetch_skid_reg
    import riscv_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  unload,
    input  logic  clear,
    input  ifid_t din,
    output ifid_t dout,
    output logic  full
);

    // Clear and unload both empty the entry and take priority over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem port and holds the
// IF/ID register consumed by decode and the hazard unit.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_stall_sel,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    fetch_unit_if.master        imem,
    output logic [XLEN-1:0]     instr_id,
    output logic [XLEN-1:0]     pc_id,
    output logic                valid_id
);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc_f, pc_f_next, pc_req;
    logic            kill, kill_next;
    logic            grant, resp, ifid_free;
    logic            ifid_load_mem, ifid_load_skid, ifid_drain;
    logic            skid_load, skid_unload, skid_full;
    ifid_t           skid_din, skid_q;

    assign grant     = (state == FETCH_REQ) && imem.gnt;
    assign resp      = (state == FETCH_WAIT) && imem.rvalid;
    assign ifid_free = !valid_id || pc_stall_sel;
    assign imem.addr = pc_f;
    assign skid_din  = '{instr: imem.rdata, pc: pc_req};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH_IDLE;
        else        state <= state_next;
    end

    // Next state; redirect never blocks leaving WAIT/HOLD since it flushes IF/ID.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE: if (!redirect_valid) state_next = FETCH_REQ;
            FETCH_REQ:  if (imem.gnt) state_next = FETCH_WAIT;
            FETCH_WAIT: begin
                if (imem.rvalid) begin
                    if (redirect_valid || kill || ifid_free) state_next = FETCH_REQ;
                    else                                     state_next = FETCH_HOLD;
                end
            end
            FETCH_HOLD: if (redirect_valid || pc_stall_sel) state_next = FETCH_REQ;
            default:    state_next = FETCH_IDLE;
        endcase
    end

    // Datapath controls; a redirect overrides stall, response and grant.
    always_comb begin
        pc_f_next      = pc_f;
        kill_next      = kill;
        ifid_load_mem  = 1'b0;
        ifid_load_skid = 1'b0;
        ifid_drain     = 1'b0;
        skid_load      = 1'b0;
        skid_unload    = 1'b0;
        if (redirect_valid) begin
            pc_f_next = align_pc(redirect_pc);
            kill_next = grant || ((state == FETCH_WAIT) && !imem.rvalid);
        end else begin
            if (grant) pc_f_next = pc_f + XLEN'(4);
            if (resp && kill) kill_next = 1'b0;
            ifid_load_mem  = resp && !kill && ifid_free;
            skid_load      = resp && !kill && !ifid_free;
            ifid_load_skid = (state == FETCH_HOLD) && pc_stall_sel && skid_full;
            skid_unload    = ifid_load_skid;
            ifid_drain     = pc_stall_sel && valid_id && !ifid_load_mem && !ifid_load_skid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f     <= RESET_PC;
            pc_req   <= '0;
            kill     <= 1'b0;
            imem.req <= 1'b0;
            valid_id <= 1'b0;
            instr_id <= NOP_INSTR;
            pc_id    <= '0;
        end else begin
            pc_f     <= pc_f_next;
            kill     <= kill_next;
            imem.req <= (state_next == FETCH_REQ);
            if (grant) pc_req <= pc_f;
            if (redirect_valid || ifid_drain) begin
                valid_id <= 1'b0;
                instr_id <= NOP_INSTR;
            end else if (ifid_load_mem) begin
                valid_id <= 1'b1;
                instr_id <= imem.rdata;
                pc_id    <= pc_req;
            end else if (ifid_load_skid) begin
                valid_id <= 1'b1;
                instr_id <= skid_q.instr;
                pc_id    <= skid_q.pc;
            end
        end
    end

    fetch_skid_reg u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (redirect_valid),
        .din    (skid_din),
        .dout   (skid_q),
        .full   (skid_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected fetch
// addresses and IF/ID loads; negedge monitors pop and compare.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_sel;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] instr_id, pc_id, instr2, pc2;
    logic        valid_id, valid2;

    fetch_unit_if mif ();
    fetch_unit_if mif2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .pc_stall_sel(stall_sel),
        .redirect_valid(redir_valid), .redirect_pc(redir_pc), .imem(mif),
        .instr_id(instr_id), .pc_id(pc_id), .valid_id(valid_id)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .pc_stall_sel(1'b1),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .imem(mif2),
        .instr_id(instr2), .pc_id(pc2), .valid_id(valid2)
    );

    always #5 clk = ~clk;

    assign mif.gnt  = mif.req;
    assign mif2.gnt = mif2.req;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 1;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_addr2[$];
    ifid_t       exp_ld[$];
    ifid_t       exp_ld2[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic ifid_t ld(input logic [31:0] instr, input logic [31:0] pc);
        ld.instr = instr;
        ld.pc    = pc;
    endfunction

    // Memory model for the main DUT: answers each grant after 'lat' cycles
    // with rdata = 0x93 + address. It is not reset with the DUT.
    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] maddr;
        pend = 0; cnt = 0; maddr = '0;
        mif.rvalid = 1'b0;
        mif.rdata  = '0;
        forever begin
            @(posedge clk);
            if (mif.req && mif.gnt) begin
                pend  = 1;
                cnt   = lat - 1;
                maddr = mif.addr;
            end
            #1;
            if (pend && cnt == 0) begin
                mif.rvalid = 1'b1;
                mif.rdata  = 32'h0000_0093 + maddr;
                pend       = 0;
            end else begin
                mif.rvalid = 1'b0;
                if (pend) cnt--;
            end
        end
    end

    // Zero-wait memory for the wrap instance.
    initial begin
        logic        g;
        logic [31:0] a;
        mif2.rvalid = 1'b0;
        mif2.rdata  = '0;
        forever begin
            @(posedge clk);
            g = mif2.req && mif2.gnt;
            a = mif2.addr;
            #1;
            mif2.rvalid = g;
            mif2.rdata  = 32'h0000_0093 + a;
        end
    end

    // Monitor: fetch addresses on requests, IF/ID contents on each new load.
    initial begin
        logic  pv, ps, pv2;
        ifid_t e;
        pv = 0; ps = 1; pv2 = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mif.req && exp_addr.size() > 0) chk("imem_addr", mif.addr, exp_addr.pop_front());
                if (valid_id && (!pv || ps) && exp_ld.size() > 0) begin
                    e = exp_ld.pop_front();
                    chk("instr_id", instr_id, e.instr);
                    chk("pc_id", pc_id, e.pc);
                end
                if (!valid_id) chk("nop_when_empty", instr_id, NOP);
                if (mif2.req && exp_addr2.size() > 0) chk("wrap_imem_addr", mif2.addr, exp_addr2.pop_front());
                if (valid2 && exp_ld2.size() > 0) begin
                    e = exp_ld2.pop_front();
                    chk("wrap_instr_id", instr2, e.instr);
                    chk("wrap_pc_id", pc2, e.pc);
                end
            end
            pv  = valid_id;
            ps  = stall_sel;
            pv2 = valid2;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two cycles, check reset values, release after a posedge.
    task automatic do_reset();
        rst_n = 1'b0; stall_sel = 1'b1; redir_valid = 1'b0; redir_pc = '0;
        repeat (2) cyc();
        chk("rst_imem_req", 32'(mif.req), 32'd0);
        chk("rst_valid_id", 32'(valid_id), 32'd0);
        chk("rst_instr_id", instr_id, NOP);
        chk("rst_pc_id", pc_id, 32'd0);
        chk("rst_imem_addr", mif.addr, 32'd0);
        chk("rst_wrap_addr", mif2.addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;
    endtask

    task automatic wait_ld(input logic [31:0] pc);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc();
            if (valid_id && pc_id == pc) found = 1;
        end
        chk("wait_load", 32'(found), 32'd1);
    endtask

    task automatic wait_req(input logic [31:0] addr);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc();
            if (mif.req && mif.addr == addr) found = 1;
        end
        chk("wait_req", 32'(found), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_addr.size() + exp_ld.size() + exp_addr2.size() + exp_ld2.size() == 0) break;
            cyc();
        end
        chk("queues_drained", 32'(exp_addr.size() + exp_ld.size() + exp_addr2.size() + exp_ld2.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall_sel = 1'b1; redir_valid = 1'b0; redir_pc = '0;

        // Straight-line fetch, zero-wait memory: one instruction per two cycles.
        lat = 1;
        rst_n = 1'b0;
        foreach (exp_addr[i]) ;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
        exp_ld.push_back(ld(32'h93, 32'h0)); exp_ld.push_back(ld(32'h97, 32'h4));
        exp_ld.push_back(ld(32'h9B, 32'h8));
        do_reset();
        repeat (3) cyc();
        chk("t1_valid_pc0", 32'(valid_id), 32'd1);
        chk("t1_pc0", pc_id, 32'h0);
        cyc();
        chk("t1_drain", 32'(valid_id), 32'd0);
        cyc();
        chk("t1_pc4", pc_id, 32'h4);
        repeat (2) cyc();
        chk("t1_pc8", pc_id, 32'h8);
        wait_drain();

        // Stall while pc 4 is in IF/ID: pc 8 parks in the skid, no requests.
        rst_n = 1'b0;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
        exp_ld.push_back(ld(32'h93, 32'h0)); exp_ld.push_back(ld(32'h97, 32'h4));
        exp_ld.push_back(ld(32'h9B, 32'h8)); exp_ld.push_back(ld(32'h9F, 32'hC));
        do_reset();
        wait_ld(32'h4);
        stall_sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t2_frozen_pc", pc_id, 32'h4);
            chk("t2_frozen_instr", instr_id, 32'h97);
            chk("t2_frozen_valid", 32'(valid_id), 32'd1);
            chk("t2_no_req", 32'(mif.req), 32'd0);
        end
        stall_sel = 1'b1;
        cyc();
        chk("t2_skid_pc", pc_id, 32'h8);
        chk("t2_skid_valid", 32'(valid_id), 32'd1);
        chk("t2_req_after_hold", mif.addr, 32'hC);
        wait_drain();

        // Redirect during WAIT for pc 0x10 (two-cycle memory): response killed.
        lat = 2;
        rst_n = 1'b0;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
        exp_addr.push_back(32'hC); exp_addr.push_back(32'h10); exp_addr.push_back(32'h100);
        exp_ld.push_back(ld(32'h93, 32'h0)); exp_ld.push_back(ld(32'h97, 32'h4));
        exp_ld.push_back(ld(32'h9B, 32'h8)); exp_ld.push_back(ld(32'h9F, 32'hC));
        exp_ld.push_back(ld(32'h193, 32'h100));
        do_reset();
        wait_req(32'h10);
        cyc();
        redir_valid = 1'b1; redir_pc = 32'h0000_0103;
        cyc();
        redir_valid = 1'b0;
        chk("t3_flush_valid", 32'(valid_id), 32'd0);
        chk("t3_flush_instr", instr_id, NOP);
        cyc();
        chk("t3_killed_valid", 32'(valid_id), 32'd0);
        chk("t3_req", 32'(mif.req), 32'd1);
        chk("t3_target", mif.addr, 32'h100);
        wait_drain();

        // Redirect coincides with rvalid while IF/ID is full and stalled.
        lat = 1;
        rst_n = 1'b0;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h200);
        exp_ld.push_back(ld(32'h93, 32'h0)); exp_ld.push_back(ld(32'h293, 32'h200));
        do_reset();
        wait_ld(32'h0);
        stall_sel = 1'b0;
        cyc();
        redir_valid = 1'b1; redir_pc = 32'h0000_0202;
        cyc();
        redir_valid = 1'b0;
        chk("t4_bubble_valid", 32'(valid_id), 32'd0);
        chk("t4_bubble_instr", instr_id, NOP);
        chk("t4_req", 32'(mif.req), 32'd1);
        chk("t4_target", mif.addr, 32'h200);
        repeat (2) cyc();
        chk("t4_new_valid", 32'(valid_id), 32'd1);
        chk("t4_new_pc", pc_id, 32'h200);
        stall_sel = 1'b1;
        wait_drain();

        // Async reset with a request outstanding; the late response is ignored.
        lat = 3;
        rst_n = 1'b0;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
        exp_ld.push_back(ld(32'h93, 32'h0)); exp_ld.push_back(ld(32'h97, 32'h4));
        do_reset();
        wait_ld(32'h4);
        stall_sel = 1'b0;
        @(posedge clk);
        #3;
        chk("t5_pre_valid", 32'(valid_id), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(valid_id), 32'd0);
        chk("t5_async_instr", instr_id, NOP);
        chk("t5_async_pc", pc_id, 32'h0);
        chk("t5_async_req", 32'(mif.req), 32'd0);
        chk("t5_async_addr", mif.addr, 32'h0);
        exp_addr.push_back(32'h0);
        exp_ld.push_back(ld(32'h93, 32'h0));
        cyc();
        rst_n = 1'b1; stall_sel = 1'b1;
        repeat (2) cyc();
        chk("t5_late_ignored", 32'(valid_id), 32'd0);
        wait_drain();

        // PC wrap on the instance reset to 0xFFFF_FFFC.
        lat = 1;
        rst_n = 1'b0;
        exp_addr2.push_back(32'hFFFF_FFFC); exp_addr2.push_back(32'h0);
        exp_ld2.push_back(ld(32'h8F, 32'hFFFF_FFFC)); exp_ld2.push_back(ld(32'h93, 32'h0));
        do_reset();
        repeat (3) cyc();
        chk("t6_wrap_addr", mif2.addr, 32'h0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
